// File: rtl/tdm_pkg.sv
// Shared types and sizes for the 1:4 TDM demultiplexer slice.
package tdm_pkg;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SLOT_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FCNT_W = 16;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef enum logic [0:0] {HUNT = 1'b0, TRACK = 1'b1} state_e;
endpackage

// File: rtl/tdm_demux1_4_if.sv
// Serial beat input and de-interleaved channel outputs of tdm_demux1_4.
// frame_cnt exists only when TDM_DEMUX_FRAME_CNT_EN is defined.
interface tdm_demux1_4_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic             din_sync;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [3:0]       y_vld;
  logic             frame_done;
  logic             locked;
  logic             sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  modport master (
`ifdef TDM_DEMUX_FRAME_CNT_EN
    input  frame_cnt,
`endif
    output din, din_vld, din_sync,
    input  y0, y1, y2, y3, y_vld, frame_done, locked, sync_err
  );

  modport slave (
`ifdef TDM_DEMUX_FRAME_CNT_EN
    output frame_cnt,
`endif
    input  din, din_vld, din_sync,
    output y0, y1, y2, y3, y_vld, frame_done, locked, sync_err
  );
endinterface

// File: rtl/tdm_slot_ctr.sv
// 2-bit slot counter: clear beats load-to-1 beats increment; last_slot flags slot 3.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  load1,
  input  logic  inc,
  output slot_t slot,
  output logic  last_slot
);
  slot_t slot_nxt;

  always_comb begin
    slot_nxt = slot;
    if (clr)        slot_nxt = '0;
    else if (load1) slot_nxt = SLOT_W'(1);
    else if (inc)   slot_nxt = slot + SLOT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot      <= '0;
      last_slot <= 1'b0;
    end else begin
      slot      <= slot_nxt;
      last_slot <= (slot_nxt == SLOT_W'(NUM_CH - 1));
    end
  end
endmodule

// File: rtl/tdm_demux1_4.sv
// De-interleaves a sync-aligned TDM stream into four registered channels.
// Optional frame counter output enabled by TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux1_4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic           clk,
  input  logic           rst,
  tdm_demux1_4_if.slave  bus
);
  localparam logic [0:0]       S_HUNT  = 1'(HUNT);
  localparam logic [0:0]       S_TRACK = 1'(TRACK);
  localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_FRAMES);

  logic [0:0]       state_q, state_n;
  logic [CNT_W-1:0] good_q, good_n, good_sat;
  logic             locked_q, locked_n;
  logic             err_q, err_n;
  logic             fd_q, fd_n;
  logic [NUM_CH-1:0] vld_q, vld_n;
  logic [WIDTH-1:0] y_q [NUM_CH];
  logic [WIDTH-1:0] y_n [NUM_CH];

  slot_t slot;
  logic  last_slot;
  logic  slot_clr, slot_ld1, slot_inc;

  tdm_slot_ctr u_slot_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr       (slot_clr),
    .load1     (slot_ld1),
    .inc       (slot_inc),
    .slot      (slot),
    .last_slot (last_slot)
  );

  assign good_sat = (good_q == LOCK_N) ? good_q : good_q + CNT_W'(1);

  // Alignment FSM, lock accounting and channel write decode.
  always_comb begin
    state_n  = state_q;
    good_n   = good_q;
    locked_n = locked_q;
    err_n    = 1'b0;
    fd_n     = 1'b0;
    vld_n    = '0;
    y_n      = y_q;
    slot_clr = 1'b0;
    slot_ld1 = 1'b0;
    slot_inc = 1'b0;
    if (bus.din_vld) begin
      if (state_q == S_HUNT) begin
        if (bus.din_sync) begin
          y_n[0]   = bus.din;
          vld_n[0] = 1'b1;
          slot_ld1 = 1'b1;
          state_n  = S_TRACK;
          good_n   = CNT_W'(1);
          locked_n = (LOCK_N == CNT_W'(1));
        end
      end else if (bus.din_sync) begin
        y_n[0]   = bus.din;
        vld_n[0] = 1'b1;
        slot_ld1 = 1'b1;
        if (slot == '0) begin
          good_n   = good_sat;
          locked_n = (good_sat == LOCK_N);
        end else begin
          err_n    = 1'b1;
          good_n   = '0;
          locked_n = 1'b0;
        end
      end else if (slot == '0) begin
        // Expected a sync here: frame lost, drop the beat and re-hunt.
        err_n    = 1'b1;
        good_n   = '0;
        locked_n = 1'b0;
        slot_clr = 1'b1;
        state_n  = S_HUNT;
      end else begin
        y_n[slot]   = bus.din;
        vld_n[slot] = 1'b1;
        slot_inc    = 1'b1;
        fd_n        = last_slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HUNT;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      fd_q     <= 1'b0;
      vld_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) y_q[k] <= '0;
    end else begin
      state_q  <= state_n;
      good_q   <= good_n;
      locked_q <= locked_n;
      err_q    <= err_n;
      fd_q     <= fd_n;
      vld_q    <= vld_n;
      y_q      <= y_n;
    end
  end

  assign bus.y0         = y_q[0];
  assign bus.y1         = y_q[1];
  assign bus.y2         = y_q[2];
  assign bus.y3         = y_q[3];
  assign bus.y_vld      = vld_q;
  assign bus.frame_done = fd_q;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = err_q;

`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [FCNT_W-1:0] fcnt_q;

  // Frames since the last sync error; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)       fcnt_q <= '0;
    else if (err_n) fcnt_q <= '0;
    else if (fd_n)  fcnt_q <= fcnt_q + FCNT_W'(1);
  end

  assign bus.frame_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_tdm_demux1_4.sv
// Self-checking bench for tdm_demux1_4: directed vector table, gap/frame-count
// sequence, then randomized stream checked against a behavioural model.
module tb_tdm_demux1_4;
  localparam int W  = 1;
  localparam int LF = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux1_4_if #(.WIDTH(W)) bus ();

  tdm_demux1_4 #(.WIDTH(W), .LOCK_FRAMES(LF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       r, v, s;
    logic [W-1:0] d;
    logic [3:0] ey;
    logic [3:0] ev;
    logic       fd, lk, er;
  } vec_t;

  vec_t tbl[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: position in frame (-1 = hunting), frames of good alignment.
  int           m_pos, m_good, m_fc;
  logic         m_lk;
  logic [W-1:0] m_y [4];
  logic [3:0]   m_vld;
  logic         m_fd, m_err;

  task automatic add(input logic r, v, s, input logic [W-1:0] d,
                     input logic [3:0] ey, ev, input logic fd, lk, er);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d;
    t.ey = ey; t.ev = ev; t.fd = fd; t.lk = lk; t.er = er;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got 0x%0h want 0x%0h", name, idx, act, exp);
  endtask

  task automatic model_step(input logic r, v, s, input logic [W-1:0] d);
    m_vld = '0; m_fd = 1'b0; m_err = 1'b0;
    if (r) begin
      m_pos = -1; m_good = 0; m_lk = 1'b0; m_fc = 0;
      for (int k = 0; k < 4; k++) m_y[k] = '0;
    end else if (v) begin
      if (m_pos < 0) begin
        if (s) begin
          m_y[0] = d; m_vld[0] = 1'b1; m_pos = 1; m_good = 1; m_lk = (m_good >= LF);
        end
      end else if (s) begin
        if (m_pos == 0) begin
          m_good = (m_good < LF) ? m_good + 1 : LF;
          if (m_good >= LF) m_lk = 1'b1;
        end else begin
          m_err = 1'b1; m_good = 0; m_lk = 1'b0;
        end
        m_y[0] = d; m_vld[0] = 1'b1; m_pos = 1;
      end else if (m_pos == 0) begin
        m_err = 1'b1; m_good = 0; m_lk = 1'b0; m_pos = -1;
      end else begin
        m_y[m_pos] = d; m_vld[m_pos] = 1'b1;
        if (m_pos == 3) begin
          m_fd = 1'b1; m_fc = (m_fc + 1) % 65536;
        end
        m_pos = (m_pos + 1) % 4;
      end
      if (m_err) m_fc = 0;
    end
  endtask

  task automatic drive(input logic r, v, s, input logic [W-1:0] d);
    rst = r; bus.din_vld = v; bus.din_sync = s; bus.din = d;
    model_step(r, v, s, d);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] act_y();
    return {bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction

  task automatic check_model(input string tag, input int idx);
    chk({tag, "_y"},      idx, 32'(act_y()),          32'({m_y[3], m_y[2], m_y[1], m_y[0]}));
    chk({tag, "_y_vld"},  idx, 32'(bus.y_vld),        32'(m_vld));
    chk({tag, "_fdone"},  idx, 32'(bus.frame_done),   32'(m_fd));
    chk({tag, "_locked"}, idx, 32'(bus.locked),       32'(m_lk));
    chk({tag, "_serr"},   idx, 32'(bus.sync_err),     32'(m_err));
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk({tag, "_fcnt"},   idx, 32'(bus.frame_cnt),    32'(m_fc));
`endif
  endtask

  initial begin
    rst = 1'b1; bus.din_vld = 1'b0; bus.din_sync = 1'b0; bus.din = '0;
    model_step(1'b1, 1'b0, 1'b0, '0);

    // r v s d  y3..y0  vld  fd lk er
    add(1,1,1,1, 4'b0000, 4'b0000, 0,0,0);
    add(1,1,0,1, 4'b0000, 4'b0000, 0,0,0);
    add(0,1,1,1, 4'b0001, 4'b0001, 0,0,0);
    add(0,1,0,0, 4'b0001, 4'b0010, 0,0,0);
    add(0,1,0,1, 4'b0101, 4'b0100, 0,0,0);
    add(0,1,0,1, 4'b1101, 4'b1000, 1,0,0);
    add(0,1,1,1, 4'b1101, 4'b0001, 0,1,0);
    add(0,1,0,0, 4'b1101, 4'b0010, 0,1,0);
    add(0,1,0,1, 4'b1101, 4'b0100, 0,1,0);
    add(0,1,0,1, 4'b1101, 4'b1000, 1,1,0);
    add(0,1,1,1, 4'b1101, 4'b0001, 0,1,0);
    add(0,0,0,0, 4'b1101, 4'b0000, 0,1,0);
    add(0,1,0,0, 4'b1101, 4'b0010, 0,1,0);
    add(0,0,0,0, 4'b1101, 4'b0000, 0,1,0);
    add(0,1,0,1, 4'b1101, 4'b0100, 0,1,0);
    add(0,0,0,0, 4'b1101, 4'b0000, 0,1,0);
    add(0,1,0,1, 4'b1101, 4'b1000, 1,1,0);
    add(0,0,1,0, 4'b1101, 4'b0000, 0,1,0);
    add(0,1,1,0, 4'b1100, 4'b0001, 0,1,0);
    add(0,1,0,1, 4'b1110, 4'b0010, 0,1,0);
    add(0,1,1,1, 4'b1111, 4'b0001, 0,0,1);
    add(0,1,0,0, 4'b1101, 4'b0010, 0,0,0);
    add(0,1,0,0, 4'b1001, 4'b0100, 0,0,0);
    add(0,1,0,0, 4'b0001, 4'b1000, 1,0,0);
    add(0,1,0,1, 4'b0001, 4'b0000, 0,0,1);
    add(0,1,0,1, 4'b0001, 4'b0000, 0,0,0);
    add(0,1,0,0, 4'b0001, 4'b0000, 0,0,0);
    add(0,1,1,0, 4'b0000, 4'b0001, 0,0,0);
    add(0,1,0,1, 4'b0010, 4'b0010, 0,0,0);
    add(1,1,0,1, 4'b0000, 4'b0000, 0,0,0);
    add(0,1,0,1, 4'b0000, 4'b0000, 0,0,0);
    add(0,1,1,1, 4'b0001, 4'b0001, 0,0,0);
    add(0,1,0,1, 4'b0011, 4'b0010, 0,0,0);
    add(0,1,0,1, 4'b0111, 4'b0100, 0,0,0);
    add(0,1,0,1, 4'b1111, 4'b1000, 1,0,0);
    add(0,1,1,0, 4'b1110, 4'b0001, 0,1,0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      chk("tbl_y",      i, 32'(act_y()),        32'(tbl[i].ey));
      chk("tbl_y_vld",  i, 32'(bus.y_vld),      32'(tbl[i].ev));
      chk("tbl_fdone",  i, 32'(bus.frame_done), 32'(tbl[i].fd));
      chk("tbl_locked", i, 32'(bus.locked),     32'(tbl[i].lk));
      chk("tbl_serr",   i, 32'(bus.sync_err),   32'(tbl[i].er));
`ifdef TDM_DEMUX_FRAME_CNT_EN
      chk("tbl_fcnt",   i, 32'(bus.frame_cnt),  32'(m_fc));
`endif
    end

    // Long gaps hold y0; then three clean frames and an early sync.
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_hold_y0", k, 32'(bus.y0),    32'(1));
      chk("gap_no_vld",  k, 32'(bus.y_vld), 32'(0));
    end
    for (int b = 0; b < 3; b++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      check_model("gapseq", b);
    end
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 4; b++) begin
        drive(1'b0, 1'b1, (b == 0), W'(b));
        check_model("frames", f * 4 + b);
      end
    end
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk("fcnt_after_3", 0, 32'(bus.frame_cnt), 32'(3));
`endif
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("early_serr", 0, 32'(bus.sync_err), 32'(1));
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk("fcnt_cleared", 0, 32'(bus.frame_cnt), 32'(0));
`endif
    check_model("early", 0);

    // Randomized stream, mostly aligned, with sync corruption and resets.
    begin
      int sp;
      logic r, v, s;
      logic [W-1:0] d;
      sp = 0;
      for (int c = 0; c < 3000; c++) begin
        r = ($urandom % 300 == 0);
        v = ($urandom % 4 != 0);
        d = W'($urandom);
        s = 1'b0;
        if (r) sp = 0;
        else if (v) begin
          s = (sp == 0);
          if ($urandom % 25 == 0) s = ~s;
          if ($urandom % 40 == 0) sp = int'($urandom % 4);
          sp = (sp + 1) % 4;
        end else if ($urandom % 3 == 0) s = 1'b1;
        drive(r, v, s, d);
        check_model("rnd", c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
